// File: rtl/dlsc_uart_rx_ext.sv
// Oversampling UART receiver: glitch filter, runtime frame format, one-word holding register.
// Define DLSC_UART_RX_BREAK_EN to add break detection and the break_det output.
module dlsc_uart_rx_ext #(
    parameter int DATA_MAX   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FILTER     = OVERSAMPLE/4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic                          rx,
    input  logic [$clog2(DATA_MAX+1)-1:0] cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_MAX-1:0]           out_data,
    output logic                          out_frame_error,
    output logic                          out_parity_error,
    output logic                          overrun
`ifdef DLSC_UART_RX_BREAK_EN
    ,
    output logic                          break_det
`endif
);

    localparam int NB_W  = $clog2(DATA_MAX+1);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE-1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE/2-1);
    localparam logic [NB_W-1:0]  NB_MAX   = NB_W'(DATA_MAX);
    localparam logic [NB_W-1:0]  NB_MIN   = NB_W'(5);
`ifdef DLSC_UART_RX_BREAK_EN
    localparam bit BREAK_EN = 1'b1;
`else
    localparam bit BREAK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state, state_next;
    logic [FILTER-1:0]   filt, filt_next;
    logic                rxf, rxf_prev;
    logic [CNT_W-1:0]    cnt;
    logic [NB_W-1:0]     bit_cnt, nb_lat, shamt;
    logic [1:0]          par_lat;
    logic                stop2_lat, stop_idx;
    logic [DATA_MAX-1:0] sreg, data_fin;
    logic                par_acc, zero_acc, ferr, perr, brk_hold;
    logic                start_det, smp, par_en, done, brk;

    // Line filter: rxf only moves once FILTER consecutive ticks agree.
    always_comb begin
        filt_next[0] = rx;
        for (int i = 1; i < FILTER; i++) filt_next[i] = filt[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt     <= '1;
            rxf      <= 1'b1;
            rxf_prev <= 1'b1;
        end else if (clk_en) begin
            filt     <= filt_next;
            rxf_prev <= rxf;
            if (&filt_next)
                rxf <= 1'b1;
            else if (~|filt_next)
                rxf <= 1'b0;
        end
    end

    assign start_det = clk_en && (state == IDLE) && rxf_prev && !rxf && !brk_hold;
    assign smp       = clk_en && (state != IDLE) && (cnt == CNT_MID);
    assign par_en    = (par_lat == 2'd1) || (par_lat == 2'd2);
    assign shamt     = NB_MAX - nb_lat;
    assign data_fin  = sreg >> shamt;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        brk        = 1'b0;
        case (state)
            IDLE:    if (start_det) state_next = START;
            START:   if (smp) state_next = rxf ? IDLE : DATA;
            DATA:    if (smp && (bit_cnt == nb_lat - 1'b1)) state_next = par_en ? PARITY : STOP;
            PARITY:  if (smp) state_next = STOP;
            STOP: begin
                if (smp) begin
                    // A break is recognised on the first stop bit, even in 2-stop mode.
                    if (BREAK_EN && !stop_idx && zero_acc && !rxf) begin
                        brk        = 1'b1;
                        state_next = IDLE;
                    end else if (!(stop2_lat && !stop_idx)) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            nb_lat    <= NB_MIN;
            par_lat   <= '0;
            stop2_lat <= 1'b0;
            stop_idx  <= 1'b0;
            sreg      <= '0;
            par_acc   <= 1'b0;
            zero_acc  <= 1'b0;
            ferr      <= 1'b0;
            perr      <= 1'b0;
            brk_hold  <= 1'b0;
        end else begin
            if (start_det) begin
                cnt       <= '0;
                bit_cnt   <= '0;
                stop_idx  <= 1'b0;
                par_lat   <= cfg_parity;
                stop2_lat <= cfg_stop2;
                sreg      <= '0;
                par_acc   <= 1'b0;
                zero_acc  <= 1'b1;
                ferr      <= 1'b0;
                perr      <= 1'b0;
                if (cfg_data_bits > NB_MAX)
                    nb_lat <= NB_MAX;
                else if (cfg_data_bits < NB_MIN)
                    nb_lat <= NB_MIN;
                else
                    nb_lat <= cfg_data_bits;
            end else if (clk_en && (state != IDLE)) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end else if (clk_en && brk_hold) begin
                // After a break, wait for one full bit time of idle line.
                if (!rxf)
                    cnt <= '0;
                else if (cnt == CNT_LAST) begin
                    cnt      <= '0;
                    brk_hold <= 1'b0;
                end else
                    cnt <= cnt + 1'b1;
            end

            if (smp) begin
                case (state)
                    DATA: begin
                        sreg     <= {rxf, sreg[DATA_MAX-1:1]};
                        par_acc  <= par_acc ^ rxf;
                        zero_acc <= zero_acc & ~rxf;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        perr     <= (par_acc ^ rxf) != (par_lat == 2'd1);
                        zero_acc <= zero_acc & ~rxf;
                    end
                    STOP: begin
                        ferr     <= ferr | ~rxf;
                        stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (brk) begin
                brk_hold <= 1'b1;
                cnt      <= '0;
            end
        end
    end

    // Holding register: a completed frame is dropped only if the old word is not being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_frame_error  <= 1'b0;
            out_parity_error <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!out_valid || out_ready) begin
                    out_valid        <= 1'b1;
                    out_data         <= data_fin;
                    out_frame_error  <= ferr | ~rxf;
                    out_parity_error <= perr;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DLSC_UART_RX_BREAK_EN
    always_ff @(posedge clk) begin
        if (rst)
            break_det <= 1'b0;
        else
            break_det <= brk;
    end
`endif

endmodule

// File: tb/tb_dlsc_uart_rx_ext.sv
// Bench for dlsc_uart_rx_ext: frames are built from fields, and the expected word,
// error flags, overrun and break counts are derived from those fields.
`timescale 1ns/1ps
module tb_dlsc_uart_rx_ext;

    localparam int DM      = 8;
    localparam int OS      = 16;
    localparam int NBW     = $clog2(DM+1);
    localparam int BIT_CYC = 2*OS;
`ifdef DLSC_UART_RX_BREAK_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        bit          fe;
        bit          pe;
    } word_t;

    logic           clk = 1'b0;
    logic           clk_en = 1'b0;
    logic           rst, rx, cfg_stop2, out_ready;
    logic [NBW-1:0] cfg_data_bits;
    logic [1:0]     cfg_parity;
    logic           out_valid, out_frame_error, out_parity_error, overrun;
    logic [DM-1:0]  out_data;
`ifdef DLSC_UART_RX_BREAK_EN
    logic           break_det;
`endif

    word_t          exp_q[$];
    int             n_checks = 0, n_err = 0;
    int             exp_ovr = 0, exp_brk = 0, ovr_seen = 0, brk_seen = 0, got_cnt = 0;
    logic [DM-1:0]  got_data = '0;
    bit             got_fe = 0, got_pe = 0;
    bit             hold_prev = 0;
    logic [DM+1:0]  hold_snap = '0;

    dlsc_uart_rx_ext #(.DATA_MAX(DM), .OVERSAMPLE(OS)) dut (
        .clk              (clk),
        .rst              (rst),
        .clk_en           (clk_en),
        .rx               (rx),
        .cfg_data_bits    (cfg_data_bits),
        .cfg_parity       (cfg_parity),
        .cfg_stop2        (cfg_stop2),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_frame_error  (out_frame_error),
        .out_parity_error (out_parity_error),
        .overrun          (overrun)
`ifdef DLSC_UART_RX_BREAK_EN
        ,
        .break_det        (break_det)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 clk_en = ~clk_en;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Every handshake consumes one expected word; a held word must not move.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 0;
        end else begin
            if (out_valid && out_ready) begin
                word_t e;
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("data", 32'(out_data), 32'(e.d[DM-1:0]));
                    check("frame_err", 32'(out_frame_error), 32'(e.fe));
                    check("parity_err", 32'(out_parity_error), 32'(e.pe));
                end
                got_data = out_data;
                got_fe   = out_frame_error;
                got_pe   = out_parity_error;
                got_cnt++;
            end
            if (out_valid && !out_ready && hold_prev)
                check("hold_stable", 32'({out_data, out_frame_error, out_parity_error}), 32'(hold_snap));
            hold_prev = out_valid && !out_ready;
            hold_snap = {out_data, out_frame_error, out_parity_error};
            if (overrun) ovr_seen++;
`ifdef DLSC_UART_RX_BREAK_EN
            if (break_det) brk_seen++;
`endif
        end
    end

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] d, input int nb, input int pm, input bit st2,
                              input bit pflip, input bit s1, input bit s2, input bit scramble,
                              input int idle_bits);
        logic [15:0] dm;
        bit          pbit, is_brk;
        word_t       w;
        dm     = d & 16'((32'h1 << nb) - 1);
        pbit   = ((pm == 1) ? ~(^dm) : ^dm) ^ pflip;
        is_brk = BRK && (dm == 0) && (!(pm == 1 || pm == 2) || !pbit) && !s1;
        w.d    = dm;
        w.fe   = !s1 || (st2 && !s2);
        w.pe   = (pm == 1 || pm == 2) && ((^dm ^ pbit) != (pm == 1));
        if (is_brk)
            exp_brk++;
        else if (out_ready || exp_q.size() == 0)
            exp_q.push_back(w);
        else
            exp_ovr++;
        cfg_data_bits = NBW'(nb);
        cfg_parity    = 2'(pm);
        cfg_stop2     = st2;
        hold_bit(1'b0);
        if (scramble) begin
            cfg_data_bits = NBW'(5);
            cfg_parity    = 2'd1;
            cfg_stop2     = 1'b1;
        end
        for (int i = 0; i < nb; i++) hold_bit(dm[i]);
        if (pm == 1 || pm == 2) hold_bit(pbit);
        hold_bit(s1);
        if (st2) hold_bit(s2);
        for (int i = 0; i < idle_bits; i++) hold_bit(1'b1);
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; out_ready = 1'b1;
        cfg_data_bits = NBW'(8); cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_fe", 32'(out_frame_error), 32'd0);
        check("rst_pe", 32'(out_parity_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (2) hold_bit(1'b1);

        send_frame(16'h00A5, 8, 0, 0, 0, 1, 1, 0, 2);
        check("a5_count", got_cnt, 1);
        check("a5_data", 32'(got_data), 32'h0A5);
        check("a5_flags", 32'({got_fe, got_pe}), 32'd0);

        send_frame(16'h0055, 7, 2, 0, 1, 1, 1, 0, 2);
        check("7e1_count", got_cnt, 2);
        check("7e1_data", 32'(got_data), 32'h55);
        check("7e1_pe", 32'(got_pe), 32'd1);

        send_frame(16'h003C, 8, 1, 0, 0, 1, 1, 0, 2);
        send_frame(16'h001F, 5, 0, 1, 0, 1, 1, 0, 2);
        check("5n2_data", 32'(got_data), 32'h1F);

        send_frame(16'h0081, 8, 0, 1, 0, 1, 0, 0, 2);
        check("stop2_count", got_cnt, 5);
        check("stop2_fe", 32'(got_fe), 32'd1);

        rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        repeat (24) hold_bit(1'b1);
        check("glitch_count", got_cnt, 5);

        send_frame(16'h00C3, 8, 0, 0, 0, 1, 1, 1, 2);
        check("cfg_hold_data", 32'(got_data), 32'hC3);

        cfg_data_bits = NBW'(8); cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        hold_bit(1'b0);
        repeat (3) hold_bit(1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        rst = 1'b0;
        repeat (24) hold_bit(1'b1);
        check("midrst_count", got_cnt, 6);
        check("midrst_overrun", ovr_seen, 0);

        out_ready = 1'b0;
        send_frame(16'h0012, 8, 0, 0, 0, 1, 1, 0, 0);
        send_frame(16'h0034, 8, 0, 0, 0, 1, 1, 0, 2);
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_data", 32'(out_data), 32'h12);
        check("b2b_overrun", ovr_seen, 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_count", got_cnt, 7);

        cfg_data_bits = NBW'(8); cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        if (BRK) exp_brk++;
        else exp_q.push_back('{d: 16'h0, fe: 1'b1, pe: 1'b0});
        repeat (20) hold_bit(1'b0);
        repeat (3) hold_bit(1'b1);
`ifdef DLSC_UART_RX_BREAK_EN
        check("brk_pulses", brk_seen, 1);
        check("brk_count", got_cnt, 7);
`else
        check("brk_count", got_cnt, 8);
        check("brk_data", 32'(got_data), 32'h0);
        check("brk_fe", 32'(got_fe), 32'd1);
`endif

        send_frame(16'h005A, 8, 0, 0, 0, 1, 1, 0, 4);
        check("after_brk_data", 32'(got_data), 32'h5A);

        check("words_missing", exp_q.size(), 0);
        check("overrun_total", ovr_seen, exp_ovr);
        check("break_total", brk_seen, exp_brk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dlsc_uart_rx_ext.md
DLSC_UART_RX_EXT -- requirements
Module: dlsc_uart_rx_ext

Interface
REQ-001 SHALL have parameter DATA_MAX, default 8, meaning the maximum data bits per frame (range 5..16).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning clk_en ticks per bit (even, >= 8).
REQ-003 SHALL have parameter FILTER, default OVERSAMPLE/4, meaning the glitch-filter depth in clk_en ticks.
REQ-004 SHALL have port clk  input  1  the single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port clk_en  input  1  oversample tick at BAUD*OVERSAMPLE.
REQ-007 SHALL have port rx  input  1  UART line, idle high.
REQ-008 SHALL have port cfg_data_bits  input  clog2(DATA_MAX+1)  data bits per frame (5..DATA_MAX).
REQ-009 SHALL have port cfg_parity  input  2  parity mode: 0 none, 1 odd, 2 even, 3 treated as none.
REQ-010 SHALL have port cfg_stop2  input  1  selects 2 stop bits when 1 and 1 stop bit when 0.
REQ-011 SHALL have port out_ready  input  1  consumer accept.
REQ-012 SHALL have port out_valid  output  1  holding register full.
REQ-013 SHALL have port out_data  output  DATA_MAX  received word.
REQ-014 SHALL have port out_frame_error  output  1  stop bit was sampled low.
REQ-015 SHALL have port out_parity_error  output  1  parity check failed.
REQ-016 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-017 SHALL have port break_det  output  1  one-cycle break pulse; exists only under DLSC_UART_RX_BREAK_EN.

Function
REQ-018 SHALL filter rx with a FILTER-deep glitch filter (reset value 1) advanced on clk_en, and SHALL use only the filtered signal (rxf) downstream.
REQ-019 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; in IDLE, a clk_en tick where the previous rxf is 1 and the current rxf is 0 SHALL move to START, clear the oversample counter and latch cfg_* for the whole frame.
REQ-020 SHALL count 0..OVERSAMPLE-1 in the oversample counter on each clk_en outside IDLE, and SHALL take one sample per bit at count OVERSAMPLE/2-1 (mid-bit).
REQ-021 In START, a sample of 1 SHALL count as a false start: return to IDLE with no output and no error.
REQ-022 In DATA, SHALL shift in exactly the latched cfg_data_bits bits LSB-first, right-aligned in out_data, with unused upper bits 0.
REQ-023 In PARITY (entered only when the latched mode is 1 or 2), SHALL set parity error when the XOR of the data bits and the parity bit is not 1 for odd or not 0 for even.
REQ-024 In STOP, SHALL sample 1 or 2 stop bits, set frame error if any is 0, and complete the frame at the mid-bit sample of the last stop bit, returning to IDLE on the same cycle so a back-to-back start can be detected.
REQ-025 On completion, SHALL load data and both error flags into the holding register and set out_valid the next cycle, if the register is empty or out_ready=1 that cycle.
REQ-026 On completion with out_valid=1 and out_ready=0, SHALL leave the held word unchanged, discard the new frame and pulse overrun for exactly 1 cycle.
REQ-027 A cycle with out_valid=1 and out_ready=1 and no completion SHALL clear out_valid; out_data and the error flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 Changes to cfg_* mid-frame SHALL have no effect until the next start detect.

Reset
REQ-029 While rst=1, SHALL force the FSM to IDLE, the oversample counter, the shift register and all outputs to 0, and the filter output and previous-rxf register to 1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no output and no overrun.

Configuration
REQ-031 With DLSC_UART_RX_BREAK_EN defined, a frame with all data bits 0, parity bit 0 (if present) and first stop bit 0 SHALL be a break.
REQ-032 A break SHALL pulse break_det for 1 cycle, SHALL NOT load the holding register, and SHALL hold the FSM in IDLE until rxf has been 1 for a full bit time.
REQ-033 Without DLSC_UART_RX_BREAK_EN, break_det SHALL be absent and the same frame SHALL be delivered as data 0 with out_frame_error=1.

Verification
REQ-034 8N1, rx byte 0xA5, out_ready=1 -> out_valid for 1 cycle, out_data=0x0A5, both error flags 0.
REQ-035 cfg_data_bits=7, even parity, 0x55 sent with a wrong parity bit -> out_data=0x55, out_parity_error=1.
REQ-036 Two frames back-to-back with out_ready=0 -> first word held, overrun pulses once, out_data equals the first word.
REQ-037 Low glitch of 0.3 bit on idle rx -> no output; 2-stop config with second stop bit 0 -> out_frame_error=1.
REQ-038 Line held low for 2 frame times -> with the macro, break_det pulses once and out_valid stays 0; without it, out_data=0 and out_frame_error=1.
